// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath/memory.
// master: the controller (drives selects/enables, observes opcode fields, flags, mem_ready).
// slave : the datapath side (drives opcode fields, flags, mem_ready; observes controls).
//   op/funct     instruction fields from the instruction register
//   zero         ALU zero flag
//   mem_ready    shared memory port completes the current access this cycle
//   memreq..illegal_op  per-state datapath selects and enables
//   mem_timeout  sticky memory wait timeout
//   state        current controller state (debug)
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       memreq;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [3:0] alucontrol;
    logic       signext;
    logic       shiftl16;
    logic       regdst;
    logic       regwrite;
    logic       memtoreg;
    logic       halfword;
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] state;

    modport master (
        input  op, funct, zero, mem_ready,
        output memreq, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
               alucontrol, signext, shiftl16, regdst, regwrite, memtoreg,
               halfword, illegal_op, mem_timeout, state
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  memreq, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
               alucontrol, signext, shiftl16, regdst, regwrite, memtoreg,
               halfword, illegal_op, mem_timeout, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Control FSM sequencing a multicycle MIPS datapath over one shared memory port.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; forces every output low while high
//   ctrl   master side of mips_multicycle_ctrl_if (opcode fields and flags in,
//          datapath selects/enables, illegal_op pulse, sticky mem_timeout, debug state out)
// Parameters:
//   WAIT_LIMIT  memory wait cycles in one state before mem_timeout sets (0 disables)
//   ENABLE_LH   nonzero: op 100001 decodes as lh; zero: it is illegal
module mips_multicycle_ctrl #(
    parameter int unsigned WAIT_LIMIT = 255,
    parameter int unsigned ENABLE_LH  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_multicycle_ctrl_if.master ctrl
);

    localparam int unsigned CNT_W = (WAIT_LIMIT > 255) ? $clog2(WAIT_LIMIT + 1) : 8;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b1010;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SLT = 4'b1011;
    localparam logic [3:0] ALU_NOR = 4'b0100;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        IEXEC  = 4'd9,
        IWB    = 4'd10,
        JUMP   = 4'd11
    } state_t;

    typedef struct packed {
        logic       memreq;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcen;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [3:0] alucontrol;
        logic       signext;
        logic       shiftl16;
        logic       regdst;
        logic       regwrite;
        logic       memtoreg;
        logic       halfword;
        logic       illegal_op;
    } dp_ctrl_t;

    state_t           state_q, state_d;
    dp_ctrl_t         dp;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;

    logic       is_lh, is_load, is_store, is_rtype, is_beq, is_imm, is_jump;
    logic       funct_legal;
    logic [3:0] funct_alu;
    logic [3:0] imm_alu;
    logic       imm_sext, imm_lui;
    logic       waiting;

    // Opcode classification
    always_comb begin
        is_lh    = (ENABLE_LH != 0) && (ctrl.op == OP_LH);
        is_load  = (ctrl.op == OP_LW) || is_lh;
        is_store = (ctrl.op == OP_SW);
        is_rtype = (ctrl.op == OP_RTYPE);
        is_beq   = (ctrl.op == OP_BEQ);
        is_imm   = (ctrl.op == OP_ADDI) || (ctrl.op == OP_ADDIU) || (ctrl.op == OP_ORI) ||
                   (ctrl.op == OP_XORI) || (ctrl.op == OP_LUI);
        is_jump  = (ctrl.op == OP_J);
    end

    // R-type funct to ALU operation
    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = ALU_AND;
        case (ctrl.funct)
            6'b100000, 6'b100001: funct_alu = ALU_ADD;
            6'b100010, 6'b100011: funct_alu = ALU_SUB;
            6'b100100:            funct_alu = ALU_AND;
            6'b100101:            funct_alu = ALU_OR;
            6'b100111:            funct_alu = ALU_NOR;
            6'b101010:            funct_alu = ALU_SLT;
            default:              funct_legal = 1'b0;
        endcase
    end

    // I-type ALU operation and immediate handling (lui is add of imm<<16, zero-extended)
    always_comb begin
        imm_alu  = ALU_ADD;
        imm_sext = 1'b0;
        imm_lui  = 1'b0;
        case (ctrl.op)
            OP_ADDI, OP_ADDIU: imm_sext = 1'b1;
            OP_ORI:            imm_alu  = ALU_OR;
            OP_XORI:           imm_alu  = ALU_XOR;
            OP_LUI:            imm_lui  = 1'b1;
            default: ;
        endcase
    end

    // State register plus wait counter and sticky timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next state and per-state datapath controls
    always_comb begin
        state_d = state_q;
        dp      = '0;
        case (state_q)
            FETCH: begin
                dp.memreq     = 1'b1;
                dp.alusrcb    = 2'b01;
                dp.alucontrol = ALU_ADD;
                // IR load and PC+4 happen in the cycle the fetch completes
                if (ctrl.mem_ready) begin
                    dp.irwrite = 1'b1;
                    dp.pcen    = 1'b1;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                dp.alusrcb    = 2'b11;
                dp.alucontrol = ALU_ADD;
                dp.signext    = 1'b1;
                if (is_load || is_store) begin
                    state_d = MEMADR;
                end else if (is_rtype) begin
                    state_d = EXEC;
                end else if (is_beq) begin
                    state_d = BRANCH;
                end else if (is_imm) begin
                    state_d = IEXEC;
                end else if (is_jump) begin
                    state_d = JUMP;
                end else begin
                    dp.illegal_op = 1'b1;
                    state_d       = FETCH;
                end
            end
            MEMADR: begin
                dp.alusrca    = 1'b1;
                dp.alusrcb    = 2'b10;
                dp.alucontrol = ALU_ADD;
                dp.signext    = 1'b1;
                state_d       = is_load ? MEMRD : MEMWR;
            end
            MEMRD: begin
                dp.memreq = 1'b1;
                dp.iord   = 1'b1;
                if (ctrl.mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                dp.regwrite = 1'b1;
                dp.memtoreg = 1'b1;
                dp.halfword = is_lh;
                state_d     = FETCH;
            end
            MEMWR: begin
                dp.memreq   = 1'b1;
                dp.iord     = 1'b1;
                dp.memwrite = 1'b1;
                if (ctrl.mem_ready) state_d = FETCH;
            end
            EXEC: begin
                dp.alusrca    = 1'b1;
                dp.alucontrol = funct_alu;
                if (funct_legal) begin
                    state_d = ALUWB;
                end else begin
                    dp.illegal_op = 1'b1;
                    state_d       = FETCH;
                end
            end
            ALUWB: begin
                dp.regwrite   = 1'b1;
                dp.regdst     = 1'b1;
                dp.alucontrol = funct_alu;
                state_d       = FETCH;
            end
            BRANCH: begin
                dp.alusrca    = 1'b1;
                dp.alucontrol = ALU_SUB;
                dp.pcsrc      = 2'b01;
                dp.pcen       = ctrl.zero;
                state_d       = FETCH;
            end
            IEXEC: begin
                dp.alusrca    = 1'b1;
                dp.alusrcb    = 2'b10;
                dp.alucontrol = imm_alu;
                dp.signext    = imm_sext;
                dp.shiftl16   = imm_lui;
                state_d       = IWB;
            end
            IWB: begin
                dp.alusrca    = 1'b1;
                dp.alusrcb    = 2'b10;
                dp.alucontrol = imm_alu;
                dp.signext    = imm_sext;
                dp.shiftl16   = imm_lui;
                dp.regwrite   = 1'b1;
                state_d       = FETCH;
            end
            JUMP: begin
                dp.pcsrc = 2'b10;
                dp.pcen  = 1'b1;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase
        if (reset) dp = '0;
    end

    // Memory wait tracking: only the three memory-access states can stall
    always_comb begin
        waiting    = ((state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR)) &&
                     !ctrl.mem_ready;
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (waiting && (wait_cnt_q != '1)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
        timeout_d = timeout_q || ((WAIT_LIMIT != 0) && (wait_cnt_d >= LIMIT));
    end

    assign ctrl.memreq      = dp.memreq;
    assign ctrl.iord        = dp.iord;
    assign ctrl.memwrite    = dp.memwrite;
    assign ctrl.irwrite     = dp.irwrite;
    assign ctrl.pcen        = dp.pcen;
    assign ctrl.pcsrc       = dp.pcsrc;
    assign ctrl.alusrca     = dp.alusrca;
    assign ctrl.alusrcb     = dp.alusrcb;
    assign ctrl.alucontrol  = dp.alucontrol;
    assign ctrl.signext     = dp.signext;
    assign ctrl.shiftl16    = dp.shiftl16;
    assign ctrl.regdst      = dp.regdst;
    assign ctrl.regwrite    = dp.regwrite;
    assign ctrl.memtoreg    = dp.memtoreg;
    assign ctrl.halfword    = dp.halfword;
    assign ctrl.illegal_op  = dp.illegal_op;
    assign ctrl.mem_timeout = timeout_q & ~reset;
    assign ctrl.state       = reset ? 4'd0 : 4'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed and random instruction
// streams compared cycle by cycle against a per-instruction phase/latency model.
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ADIU = 6'b001001;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LH   = 6'b100001;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b1010;
    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_XOR = 4'b0101;
    localparam logic [3:0] A_SLT = 4'b1011;
    localparam logic [3:0] A_NOR = 4'b0100;

    localparam int K_ILL = 0, K_LOAD = 1, K_STORE = 2, K_R = 3, K_BEQ = 4, K_IMM = 5, K_J = 6;

    logic clk = 1'b0;
    logic reset, reset4;
    int   passed = 0;
    int   total  = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus ();
    mips_multicycle_ctrl_if bus4 ();

    mips_multicycle_ctrl #(.WAIT_LIMIT(255), .ENABLE_LH(1)) dut (
        .clk(clk), .reset(reset), .ctrl(bus)
    );
    mips_multicycle_ctrl #(.WAIT_LIMIT(4), .ENABLE_LH(0)) dut4 (
        .clk(clk), .reset(reset4), .ctrl(bus4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int op_kind(input logic [5:0] op);
        case (op)
            OP_LW, OP_LH:                                 return K_LOAD;
            OP_SW:                                        return K_STORE;
            OP_R:                                         return K_R;
            OP_BEQ:                                       return K_BEQ;
            OP_ADDI, OP_ADIU, OP_ORI, OP_XORI, OP_LUI:    return K_IMM;
            OP_J:                                         return K_J;
            default:                                      return K_ILL;
        endcase
    endfunction

    // {known, alucontrol} for an R-type funct
    function automatic logic [4:0] funct_info(input logic [5:0] fn);
        case (fn)
            6'b100000, 6'b100001: return {1'b1, A_ADD};
            6'b100010, 6'b100011: return {1'b1, A_SUB};
            6'b100100:            return {1'b1, A_AND};
            6'b100101:            return {1'b1, A_OR};
            6'b101010:            return {1'b1, A_SLT};
            6'b100111:            return {1'b1, A_NOR};
            default:              return 5'b0;
        endcase
    endfunction

    function automatic logic [20:0] obs_vec();
        return {bus.memreq, bus.iord, bus.memwrite, bus.irwrite, bus.pcen, bus.pcsrc,
                bus.alusrca, bus.alusrcb, bus.alucontrol, bus.signext, bus.shiftl16,
                bus.regdst, bus.regwrite, bus.memtoreg, bus.halfword, bus.illegal_op};
    endfunction

    // Expected control vector for a given phase (numbered as the debug state)
    function automatic logic [20:0] exp_out(input int ph, input logic [5:0] op, input logic [5:0] fn,
                                            input logic z, input logic rdy);
        logic memreq, iord, memwrite, irwrite, pcen, alusrca, signext, shiftl16;
        logic regdst, regwrite, memtoreg, halfword, illegal;
        logic [1:0] pcsrc, alusrcb;
        logic [3:0] alu;
        logic [4:0] fi;
        {memreq, iord, memwrite, irwrite, pcen, alusrca, signext, shiftl16} = 8'b0;
        {regdst, regwrite, memtoreg, halfword, illegal} = 5'b0;
        pcsrc = 2'b00; alusrcb = 2'b00; alu = 4'b0000;
        fi = funct_info(fn);
        case (ph)
            0:  begin memreq = 1; alusrcb = 2'b01; alu = A_ADD; irwrite = rdy; pcen = rdy; end
            1:  begin alusrcb = 2'b11; alu = A_ADD; signext = 1; illegal = (op_kind(op) == K_ILL); end
            2:  begin alusrca = 1; alusrcb = 2'b10; alu = A_ADD; signext = 1; end
            3:  begin memreq = 1; iord = 1; end
            4:  begin regwrite = 1; memtoreg = 1; halfword = (op == OP_LH); end
            5:  begin memreq = 1; iord = 1; memwrite = 1; end
            6:  begin alusrca = 1; alu = fi[3:0]; illegal = !fi[4]; end
            7:  begin regwrite = 1; regdst = 1; alu = fi[3:0]; end
            8:  begin alusrca = 1; alu = A_SUB; pcsrc = 2'b01; pcen = z; end
            9, 10: begin
                alusrca = 1; alusrcb = 2'b10; regwrite = (ph == 10);
                case (op)
                    OP_ORI:  alu = A_OR;
                    OP_XORI: alu = A_XOR;
                    OP_LUI:  begin alu = A_ADD; shiftl16 = 1; end
                    default: begin alu = A_ADD; signext = 1; end
                endcase
            end
            11: begin pcsrc = 2'b10; pcen = 1; end
            default: ;
        endcase
        return {memreq, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb, alu,
                signext, shiftl16, regdst, regwrite, memtoreg, halfword, illegal};
    endfunction

    // One cycle: drive mem_ready, sample mid-cycle, advance to next falling edge
    task automatic step(input int ph, input logic rdy);
        bus.mem_ready = rdy;
        #1;
        check($sformatf("state ph%0d", ph), 32'(bus.state), 32'(ph));
        check($sformatf("outs ph%0d op%0h fn%0h", ph, bus.op, bus.funct), 32'(obs_vec()),
              32'(exp_out(ph, bus.op, bus.funct, bus.zero, rdy)));
        check($sformatf("timeout ph%0d", ph), 32'(bus.mem_timeout), 32'd0);
        @(negedge clk);
    endtask

    // Full instruction: wf wait cycles in fetch, wm wait cycles in the data access
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int wf, input int wm);
        int path[$];
        int nw;
        logic rdy;
        bus.op = op; bus.funct = fn; bus.zero = z;
        path.push_back(0);
        path.push_back(1);
        case (op_kind(op))
            K_LOAD:  begin path.push_back(2); path.push_back(3); path.push_back(4); end
            K_STORE: begin path.push_back(2); path.push_back(5); end
            K_R:     begin path.push_back(6); if (funct_info(fn) >= 5'h10) path.push_back(7); end
            K_BEQ:   path.push_back(8);
            K_IMM:   begin path.push_back(9); path.push_back(10); end
            K_J:     path.push_back(11);
            default: ;
        endcase
        foreach (path[i]) begin
            nw = (path[i] == 0) ? wf : ((path[i] == 3 || path[i] == 5) ? wm : 0);
            for (int c = 0; c <= nw; c++) begin
                if (path[i] == 0 || path[i] == 3 || path[i] == 5) rdy = (c == nw);
                else rdy = 1'($urandom_range(0, 1));
                step(path[i], rdy);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] op_tbl [11] = '{OP_R, OP_J, OP_BEQ, OP_ADDI, OP_ADIU, OP_ORI,
                                   OP_XORI, OP_LUI, OP_LH, OP_LW, OP_SW};
        logic [5:0] fn_tbl [8] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                                  6'b100100, 6'b100101, 6'b101010, 6'b100111};
        logic [5:0] rop, rfn;

        bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        bus4.op = OP_LH; bus4.funct = 6'd0; bus4.zero = 1'b0; bus4.mem_ready = 1'b1;
        reset = 1'b1; reset4 = 1'b1;
        @(negedge clk); @(negedge clk);
        #1;
        check("reset outs", 32'(obs_vec()), 32'd0);
        check("reset state", 32'(bus.state), 32'd0);
        check("reset timeout", 32'(bus.mem_timeout), 32'd0);
        reset = 1'b0;

        // Directed cases
        run_instr(OP_R,   6'b100000, 1'b0, 0, 0);   // add: 0,1,6,7
        run_instr(OP_LH,  6'd0,      1'b0, 0, 3);   // lh, 3 waits in MEMRD: 8 cycles
        run_instr(OP_BEQ, 6'd0,      1'b1, 0, 0);   // taken
        run_instr(OP_BEQ, 6'd0,      1'b0, 0, 0);   // not taken
        run_instr(6'b111111, 6'd0,   1'b0, 0, 0);   // illegal op
        run_instr(OP_R,   6'b111111, 1'b0, 0, 0);   // illegal funct
        run_instr(OP_LUI, 6'd0,      1'b0, 0, 0);
        run_instr(OP_ORI, 6'd0,      1'b0, 1, 0);
        run_instr(OP_SW,  6'd0,      1'b0, 2, 2);
        run_instr(OP_J,   6'd0,      1'b0, 0, 0);
        run_instr(OP_LW,  6'd0,      1'b0, 1, 1);

        // Random stream
        for (int n = 0; n < 80; n++) begin
            rop = ($urandom_range(0, 11) == 0) ? 6'($urandom) : op_tbl[$urandom_range(0, 10)];
            rfn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_tbl[$urandom_range(0, 7)];
            run_instr(rop, rfn, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)));
        end

        // sw interrupted by reset while in MEMWR
        bus.op = OP_SW; bus.funct = 6'd0;
        step(0, 1'b1);
        step(1, 1'b1);
        step(2, 1'b1);
        bus.mem_ready = 1'b0;
        #1;
        check("sw in memwr state", 32'(bus.state), 32'd5);
        check("sw in memwr memwrite", 32'(bus.memwrite), 32'd1);
        reset = 1'b1;
        #1;
        check("mid reset outs", 32'(obs_vec()), 32'd0);
        check("mid reset state", 32'(bus.state), 32'd0);
        check("mid reset memwrite", 32'(bus.memwrite), 32'd0);
        @(negedge clk);
        #1;
        check("held reset outs", 32'(obs_vec()), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        run_instr(OP_SW, 6'd0, 1'b0, 0, 1);  // state must be back at fetch
        run_instr(OP_ADDI, 6'd0, 1'b0, 0, 0);

        // Second instance: lh disabled, WAIT_LIMIT = 4
        reset4 = 1'b0;
        #1;
        check("t4 fetch state", 32'(bus4.state), 32'd0);
        @(negedge clk);
        #1;
        check("t4 lh decode state", 32'(bus4.state), 32'd1);
        check("t4 lh illegal", 32'(bus4.illegal_op), 32'd1);
        @(negedge clk);
        bus4.mem_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            check($sformatf("t4 wait%0d state", k), 32'(bus4.state), 32'd0);
            check($sformatf("t4 wait%0d illegal", k), 32'(bus4.illegal_op), 32'd0);
            check($sformatf("t4 wait%0d timeout", k), 32'(bus4.mem_timeout), (k >= 5) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        bus4.mem_ready = 1'b1;
        #1;
        check("t4 sticky in fetch", 32'(bus4.mem_timeout), 32'd1);
        @(negedge clk);
        #1;
        check("t4 sticky after fetch", 32'(bus4.mem_timeout), 32'd1);
        check("t4 decode state", 32'(bus4.state), 32'd1);
        reset4 = 1'b1;
        #1;
        check("t4 timeout during reset", 32'(bus4.mem_timeout), 32'd0);
        @(negedge clk);
        reset4 = 1'b0;
        #1;
        check("t4 timeout after reset", 32'(bus4.mem_timeout), 32'd0);
        check("t4 state after reset", 32'(bus4.state), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
